spart_fifo: RTL and testbench

Parametrised successor to the single-byte SPART: a memory-mapped asynchronous serial port with independent TX and RX FIFOs, configurable data width and a 16-bit programmable baud divisor. It sits on the processor I/O bus via iocs/iorw/ioaddr/databus and drives txd/rxd on GPIO. It adds buffering, sticky error status and false-start rejection.

---
 rtl/spart_fifo.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_spart_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spart_fifo.sv
`timescale 1ns/1ps
// spart_fifo -- memory-mapped asynchronous serial port with TX/RX FIFOs.
//
// Ports:
//   clk      system clock (single domain)
//   rst_n    synchronous active-low reset
//   iocs     chip select; iorw 1=read 0=write; ioaddr register select
//   databus  bidirectional bus, driven only while iocs && iorw
//   rda      RX FIFO not empty (registered)
//   tbr      TX FIFO not full (registered)
//   txd      serial out, idle high; rxd serial in (asynchronous)
//
// Register map: 00 data (W push TX / R pop RX), 01 status
//   {2'b0, par_err, frm_err, rx_ovf, tx_idle, rda, tbr} (read clears the
//   sticky bits), 10 divisor[7:0], 11 divisor[15:8].
//
// Optional feature macro: PARITY_EN adds an even parity bit after the data
// bits on both TX and RX; without it par_err reads constant 0.

// Circular FIFO with registered not_empty/not_full flags.
module spart_fifo_q #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         not_empty,
   output logic         not_full
);
   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r, rd_ptr_r;
   logic [AW:0]   count_r, count_nxt_s;
   logic          push_ok_s, pop_ok_s;

   // Accept/reject decisions use the pre-edge count; a push into a full
   // FIFO is dropped even if a pop happens in the same cycle.
   always_comb begin
      push_ok_s = push && (count_r != FULL_CNT);
      pop_ok_s  = pop && (count_r != {(AW+1){1'b0}});
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_nxt_s = count_r + (AW+1)'(1);
         2'b01:   count_nxt_s = count_r - (AW+1)'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   assign rdata = mem_r[rd_ptr_r];

   // Storage array write port.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointers, count and flags; pointers wrap naturally (DEPTH is 2^AW).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r  <= {AW{1'b0}};
         rd_ptr_r  <= {AW{1'b0}};
         count_r   <= {(AW+1){1'b0}};
         not_empty <= 1'b0;
         not_full  <= 1'b1;
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         count_r   <= count_nxt_s;
         not_empty <= (count_nxt_s != {(AW+1){1'b0}});
         not_full  <= (count_nxt_s != FULL_CNT);
      end
   end
endmodule

module spart_fifo #(
   parameter int          DATA_BITS   = 8,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'h028B
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   inout  wire  [7:0] databus,
   output logic       rda,
   output logic       tbr,
   output logic       txd,
   input  logic       rxd
);
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd3;
`endif
   localparam logic [2:0] ST_STOP   = 3'd4;
   localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS-1);

   logic [15:0]          div_r;
   logic [7:0]           rdata_s;
   logic                 tx_push_s, rx_pop_s, stat_rd_s;
   logic [DATA_BITS-1:0] tx_head_s, rx_head_s;
   logic                 tx_ne_s, tx_nf_s, rx_ne_s, rx_nf_s;
   logic                 tx_pop_s, tx_tick_s, tx_idle_s;
   logic [2:0]           tx_state_r, tx_idx_r, rx_state_r, rx_idx_r;
   logic [15:0]          tx_cnt_r, rx_cnt_r;
   logic [3:0]           tx_samp_r, rx_samp_r;
   logic [DATA_BITS-1:0] tx_sh_r, rx_sh_r;
   logic                 txd_r;
   logic                 rx_s1_r, rx_s2_r, rx_prev_r;
   logic                 rx_tick_s, rx_mid_s, rx_end_s, rx_fall_s, rx_push_s;
   logic                 rx_par_bad_s, frm_set_s, par_set_s, ovf_set_s;
   logic                 par_err_r, frm_err_r, rx_ovf_r;
`ifdef PARITY_EN
   logic                 tx_par_r, rx_par_r;

   function automatic logic even_par(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction
`endif

   // Bus decode
   assign tx_push_s = iocs && !iorw && (ioaddr == 2'b00);
   assign rx_pop_s  = iocs &&  iorw && (ioaddr == 2'b00);
   assign stat_rd_s = iocs &&  iorw && (ioaddr == 2'b01);

   spart_fifo_q #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst_n(rst_n), .push(tx_push_s), .pop(tx_pop_s),
      .wdata(databus[DATA_BITS-1:0]), .rdata(tx_head_s),
      .not_empty(tx_ne_s), .not_full(tx_nf_s));

   spart_fifo_q #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst_n(rst_n), .push(rx_push_s), .pop(rx_pop_s),
      .wdata(rx_sh_r), .rdata(rx_head_s),
      .not_empty(rx_ne_s), .not_full(rx_nf_s));

   assign rda       = rx_ne_s;
   assign tbr       = tx_nf_s;
   assign txd       = txd_r;
   assign tx_idle_s = !tx_ne_s && (tx_state_r == ST_IDLE);

   // Combinational read mux; an empty RX FIFO reads as zero.
   always_comb begin
      rdata_s = 8'h00;
      case (ioaddr)
         2'b00: begin
            if (rx_ne_s) rdata_s[DATA_BITS-1:0] = rx_head_s;
            else         rdata_s = 8'h00;
         end
         2'b01:   rdata_s = {2'b00, par_err_r, frm_err_r, rx_ovf_r, tx_idle_s, rx_ne_s, tx_nf_s};
         2'b10:   rdata_s = div_r[7:0];
         2'b11:   rdata_s = div_r[15:8];
         default: rdata_s = 8'h00;
      endcase
   end

   assign databus = (iocs && iorw) ? rdata_s : 8'bzzzzzzzz;

   // Divisor register writes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_r <= DEFAULT_DIV;
      end else if (iocs && !iorw && (ioaddr == 2'b10)) begin
         div_r[7:0] <= databus;
      end else if (iocs && !iorw && (ioaddr == 2'b11)) begin
         div_r[15:8] <= databus;
      end
   end

   // TX pops when idle with data, or at the end of a stop bit for back-to-back frames.
   assign tx_tick_s = (tx_cnt_r == 16'd0);
   assign tx_pop_s  = tx_ne_s && ((tx_state_r == ST_IDLE) ||
                      ((tx_state_r == ST_STOP) && tx_tick_s && (tx_samp_r == 4'd15)));

   // TX FSM: each bit spans 16 oversample ticks of (div+1) clocks.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_state_r <= ST_IDLE;
         tx_cnt_r   <= DEFAULT_DIV;
         tx_samp_r  <= 4'd0;
         tx_idx_r   <= 3'd0;
         tx_sh_r    <= {DATA_BITS{1'b0}};
         txd_r      <= 1'b1;
`ifdef PARITY_EN
         tx_par_r   <= 1'b0;
`endif
      end else if (tx_pop_s) begin
         tx_state_r <= ST_START;
         tx_cnt_r   <= div_r;
         tx_samp_r  <= 4'd0;
         tx_idx_r   <= 3'd0;
         tx_sh_r    <= tx_head_s;
         txd_r      <= 1'b0;
`ifdef PARITY_EN
         tx_par_r   <= even_par(tx_head_s);
`endif
      end else begin
         tx_cnt_r <= tx_tick_s ? div_r : tx_cnt_r - 16'd1;
         if (tx_tick_s) tx_samp_r <= tx_samp_r + 4'd1;
         if (tx_tick_s && (tx_samp_r == 4'd15)) begin
            case (tx_state_r)
               ST_START: begin
                  tx_state_r <= ST_DATA;
                  txd_r      <= tx_sh_r[0];
               end
               ST_DATA: begin
                  if (tx_idx_r == LAST_IDX) begin
`ifdef PARITY_EN
                     tx_state_r <= ST_PARITY;
                     txd_r      <= tx_par_r;
`else
                     tx_state_r <= ST_STOP;
                     txd_r      <= 1'b1;
`endif
                  end else begin
                     tx_idx_r <= tx_idx_r + 3'd1;
                     tx_sh_r  <= tx_sh_r >> 1;
                     txd_r    <= tx_sh_r[1];
                  end
               end
`ifdef PARITY_EN
               ST_PARITY: begin
                  tx_state_r <= ST_STOP;
                  txd_r      <= 1'b1;
               end
`endif
               default: begin
                  tx_state_r <= ST_IDLE;
                  txd_r      <= 1'b1;
               end
            endcase
         end
      end
   end

   // rxd synchroniser plus previous-value flop for falling-edge detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_s1_r   <= 1'b1;
         rx_s2_r   <= 1'b1;
         rx_prev_r <= 1'b1;
      end else begin
         rx_s1_r   <= rxd;
         rx_s2_r   <= rx_s1_r;
         rx_prev_r <= rx_s2_r;
      end
   end

   // RX sampling strobes: mid = 8th tick of a bit, end = 16th tick.
   always_comb begin
      rx_tick_s = (rx_cnt_r == 16'd0);
      rx_mid_s  = rx_tick_s && (rx_samp_r == 4'd7);
      rx_end_s  = rx_tick_s && (rx_samp_r == 4'd15);
      rx_fall_s = rx_prev_r && !rx_s2_r;
`ifdef PARITY_EN
      rx_par_bad_s = even_par(rx_sh_r) ^ rx_par_r;
`else
      rx_par_bad_s = 1'b0;
`endif
      frm_set_s = (rx_state_r == ST_STOP) && rx_mid_s && !rx_s2_r;
      par_set_s = (rx_state_r == ST_STOP) && rx_mid_s && rx_s2_r && rx_par_bad_s;
      rx_push_s = (rx_state_r == ST_STOP) && rx_mid_s && rx_s2_r && !rx_par_bad_s;
      ovf_set_s = rx_push_s && !rx_nf_s;
   end

   // RX FSM; leaves STOP at mid-bit so the next start edge is caught.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_state_r <= ST_IDLE;
         rx_cnt_r   <= DEFAULT_DIV;
         rx_samp_r  <= 4'd0;
         rx_idx_r   <= 3'd0;
         rx_sh_r    <= {DATA_BITS{1'b0}};
`ifdef PARITY_EN
         rx_par_r   <= 1'b0;
`endif
      end else if ((rx_state_r == ST_IDLE) && rx_fall_s) begin
         rx_state_r <= ST_START;
         rx_cnt_r   <= div_r;
         rx_samp_r  <= 4'd0;
         rx_idx_r   <= 3'd0;
      end else begin
         rx_cnt_r <= rx_tick_s ? div_r : rx_cnt_r - 16'd1;
         if (rx_tick_s) rx_samp_r <= rx_samp_r + 4'd1;
         case (rx_state_r)
            ST_START: begin
               if (rx_mid_s && rx_s2_r) rx_state_r <= ST_IDLE;
               else if (rx_end_s)       rx_state_r <= ST_DATA;
            end
            ST_DATA: begin
               if (rx_mid_s) rx_sh_r <= {rx_s2_r, rx_sh_r[DATA_BITS-1:1]};
               if (rx_end_s) begin
                  if (rx_idx_r == LAST_IDX) begin
`ifdef PARITY_EN
                     rx_state_r <= ST_PARITY;
`else
                     rx_state_r <= ST_STOP;
`endif
                  end else begin
                     rx_idx_r <= rx_idx_r + 3'd1;
                  end
               end
            end
`ifdef PARITY_EN
            ST_PARITY: begin
               if (rx_mid_s) rx_par_r   <= rx_s2_r;
               if (rx_end_s) rx_state_r <= ST_STOP;
            end
`endif
            ST_STOP: begin
               if (rx_mid_s) rx_state_r <= ST_IDLE;
            end
            default: rx_state_r <= ST_IDLE;
         endcase
      end
   end

   // Sticky status: a status read clears, a same-cycle event still sets.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         par_err_r <= 1'b0;
         frm_err_r <= 1'b0;
         rx_ovf_r  <= 1'b0;
      end else begin
         par_err_r <= (par_err_r && !stat_rd_s) || par_set_s;
         frm_err_r <= (frm_err_r && !stat_rd_s) || frm_set_s;
         rx_ovf_r  <= (rx_ovf_r  && !stat_rd_s) || ovf_set_s;
      end
   end
endmodule

// File: tb/tb_spart_fifo.sv
`timescale 1ns/1ps
module tb_spart_fifo;
   localparam int DB = 8;
`ifdef PARITY_EN
   localparam int NPAR = 1;
`else
   localparam int NPAR = 0;
`endif
   localparam int FRAME_BITS = DB + NPAR + 2;

   logic       clk = 1'b0, rst_n = 1'b0, iocs = 1'b0, iorw = 1'b0;
   logic [1:0] ioaddr = 2'b00;
   wire  [7:0] databus;
   logic [7:0] drv_data = 8'h00;
   logic       drv_en = 1'b0, rx_drv = 1'b1, loopback = 1'b0;
   logic       rda, tbr, txd, rxd;
   int         compared = 0, mismatched = 0;

   assign databus = drv_en ? drv_data : 8'bzzzzzzzz;
   assign rxd     = loopback ? txd : rx_drv;

   always #5 clk = ~clk;

   spart_fifo dut (.clk(clk), .rst_n(rst_n), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
                   .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd));

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk); iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv_data = d; drv_en = 1'b1;
      @(negedge clk); iocs = 1'b0; drv_en = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk); iocs = 1'b1; iorw = 1'b1; ioaddr = a;
      #1 d = databus;
      @(negedge clk); iocs = 1'b0; iorw = 1'b0;
   endtask

   task automatic set_div(input logic [15:0] d);
      bus_write(2'b10, d[7:0]);
      bus_write(2'b11, d[15:8]);
   endtask

   // Serial frame as a bit list, index 0 transmitted first.
   function automatic logic [15:0] frame_of(input logic [7:0] d, input logic stop);
      logic [15:0] f;
      f = 16'hFFFF;
      f[0] = 1'b0;
      for (int i = 0; i < DB; i++) f[1+i] = d[i];
`ifdef PARITY_EN
      f[DB+1] = ^d;
`endif
      f[FRAME_BITS-1] = stop;
      return f;
   endfunction

   task automatic send_rx_frame(input logic [15:0] f, input int bclk);
      for (int b = 0; b < FRAME_BITS; b++) begin
         rx_drv = f[b];
         repeat (bclk) @(negedge clk);
      end
      rx_drv = 1'b1;
      repeat (2*bclk) @(negedge clk);
   endtask

   function automatic logic [7:0] st(input logic par, input logic frm, input logic ovf,
                                     input logic idle, input logic r, input logic t);
      return {2'b00, par, frm, ovf, idle, r, t};
   endfunction

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   logic [7:0]  rd, d;
   logic [15:0] f, dv;
   logic [7:0]  q[$];
   int          bcnt, mcount, pre, bit_clks;
   bit          busy, push_ok, pop_ok;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_txd", txd, 16'd1);
      check("rst_rda", rda, 16'd0);
      check("rst_tbr", tbr, 16'd1);
      rst_n = 1'b1;
      bus_read(2'b01, rd); check("rst_status", rd, st(0,0,0,1,0,1));
      bus_read(2'b10, rd); check("rst_div_lo", rd, 16'h8B);
      bus_read(2'b11, rd); check("rst_div_hi", rd, 16'h02);

      // Loopback 0xB4 with 64-clock bits, checking first/last cycle of each bit
      loopback = 1'b1;
      set_div(16'h0003);
      bus_write(2'b00, 8'hB4);
      check("tx_before_pop", txd, 16'd1);
      f = frame_of(8'hB4, 1'b1);
      for (int j = 0; j < FRAME_BITS*64; j++) begin
         @(negedge clk);
         if ((j % 64) == 0 || (j % 64) == 63)
            check($sformatf("tx_bit%0d_c%0d", j/64, j%64), txd, f[j/64]);
         if (j == (FRAME_BITS-1)*64 - 1) check("rda_before_stop", rda, 16'd0);
      end
      check("rda_after_frame", rda, 16'd1);
      bus_read(2'b00, rd); check("rx_b4", rd, 16'hB4);
      check("rda_after_pop", rda, 16'd0);
      bus_read(2'b01, rd); check("status_idle", rd, st(0,0,0,1,0,1));

`ifdef PARITY_EN
      // Parity bit of 0x07 is 1
      bus_write(2'b00, 8'h07);
      repeat ((DB+1)*64 + 33) @(negedge clk);
      check("tx_parity_bit", txd, 16'd1);
      repeat (200) @(negedge clk);
      bus_read(2'b00, rd); check("rx_07_par", rd, 16'h07);
`endif

      // Random loopback batches, back-to-back frames
      for (int n = 0; n < 3; n++) begin
         dv = 16'($urandom_range(0, 2));
         set_div(dv);
         bcnt = $urandom_range(2, 5);
         for (int k = 0; k < bcnt; k++) begin
            d = 8'($urandom);
            q.push_back(d);
            bus_write(2'b00, d);
         end
         repeat (bcnt*FRAME_BITS*16*(int'(dv)+1) + 100) @(negedge clk);
         while (q.size() > 0) begin
            check($sformatf("rnd%0d_rda", n), rda, 16'd1);
            bus_read(2'b00, rd);
            check($sformatf("rnd%0d_data", n), rd, q.pop_front());
         end
         check($sformatf("rnd%0d_rda_empty", n), rda, 16'd0);
         bus_read(2'b01, rd); check($sformatf("rnd%0d_status", n), rd, st(0,0,0,1,0,1));
      end

      // TX FIFO fill with slow divisor, one push per cycle
      loopback = 1'b0; rx_drv = 1'b1;
      set_div(16'hFFFF);
      mcount = 0; busy = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; drv_data = 8'(k+1); drv_en = 1'b1;
         @(negedge clk);
         pre = mcount;
         push_ok = (pre < 8);
         pop_ok = !busy && (pre > 0);
         mcount = pre + (push_ok ? 1 : 0) - (pop_ok ? 1 : 0);
         if (pop_ok) busy = 1'b1;
         check($sformatf("fill_tbr%0d", k), tbr, (mcount < 8) ? 16'd1 : 16'd0);
      end
      iocs = 1'b0; drv_en = 1'b0;
      repeat (100) @(negedge clk);
      check("fill_txd_start", txd, 16'd0);
      bus_read(2'b01, rd); check("fill_status", rd, st(0,0,0,0,0,0));

      // Reset in the middle of that frame
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_txd", txd, 16'd1);
      check("midrst_tbr", tbr, 16'd1);
      check("midrst_rda", rda, 16'd0);
      rst_n = 1'b1;
      bus_read(2'b10, rd); check("midrst_div_lo", rd, 16'h8B);
      bus_read(2'b11, rd); check("midrst_div_hi", rd, 16'h02);
      bus_read(2'b01, rd); check("midrst_status", rd, st(0,0,0,1,0,1));

      // RX overflow: 9 frames, 8 kept
      bit_clks = 16;
      set_div(16'h0000);
      for (int k = 0; k < 9; k++) begin
         d = 8'($urandom);
         if (q.size() < 8) q.push_back(d);
         send_rx_frame(frame_of(d, 1'b1), bit_clks);
      end
      bus_read(2'b01, rd); check("ovf_status", rd, st(0,0,1,1,1,1));
      bus_read(2'b01, rd); check("ovf_cleared", rd, st(0,0,0,1,1,1));
      while (q.size() > 0) begin
         bus_read(2'b00, rd);
         check("ovf_data", rd, q.pop_front());
      end
      check("ovf_rda_empty", rda, 16'd0);
      bus_read(2'b00, rd); check("empty_read", rd, 16'h00);

      // Framing error
      send_rx_frame(frame_of(8'h5A, 1'b0), bit_clks);
      check("frm_rda", rda, 16'd0);
      bus_read(2'b01, rd); check("frm_status", rd, st(0,1,0,1,0,1));
      bus_read(2'b01, rd); check("frm_cleared", rd, st(0,0,0,1,0,1));

      // 20-clock glitch at DIV=3 is a false start
      set_div(16'h0003);
      rx_drv = 1'b0;
      repeat (20) @(negedge clk);
      rx_drv = 1'b1;
      repeat (200) @(negedge clk);
      check("glitch_rda", rda, 16'd0);
      bus_read(2'b01, rd); check("glitch_status", rd, st(0,0,0,1,0,1));

`ifdef PARITY_EN
      // 0x07 received with parity 0 is dropped with par_err
      f = frame_of(8'h07, 1'b1);
      f[DB+1] = ~f[DB+1];
      send_rx_frame(f, 64);
      check("par_rda", rda, 16'd0);
      bus_read(2'b01, rd); check("par_status", rd, st(1,0,0,1,0,1));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
